// File: rtl/blocb_arbiter_if.sv
// -----------------------------------------------------------------------------
// blocb_arbiter_if
// Bundles the requester handshakes and the shared-block operand/result wires
// of blocb_arbiter.
//   req0/abc0, req1/abc1 : requests and {a,b,c} operand triples
//   gnt0/gnt1            : one-cycle grants
//   blk_a/blk_b/blk_c    : operands driven to the shared combinational block
//   blk_y                : result returned by the shared block
//   done/res/res_id      : result-valid pulse, captured result, owning requester
// Modports: slave = arbiter side, master = requesters plus shared block side.
// -----------------------------------------------------------------------------
interface blocb_arbiter_if;
   logic       req0;
   logic [2:0] abc0;
   logic       req1;
   logic [2:0] abc1;
   logic       gnt0;
   logic       gnt1;
   logic       blk_a;
   logic       blk_b;
   logic       blk_c;
   logic       blk_y;
   logic       done;
   logic       res;
   logic       res_id;

   modport slave (
      input  req0, abc0, req1, abc1, blk_y,
      output gnt0, gnt1, blk_a, blk_b, blk_c, done, res, res_id
   );

   modport master (
      output req0, abc0, req1, abc1, blk_y,
      input  gnt0, gnt1, blk_a, blk_b, blk_c, done, res, res_id
   );
endinterface

// File: rtl/blocb_arbiter.sv
// -----------------------------------------------------------------------------
// blocb_arbiter
// Shares one 3-input combinational block between two requesters. A winner is
// picked in IDLE, its operands are held on blk_a/b/c for SETTLE cycles, then
// blk_y is captured into res with a one-cycle done pulse tagged by res_id.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : blocb_arbiter_if.slave (requests, grants, block operands/result)
// Parameter SETTLE: DRIVE cycles before blk_y is sampled, legal range 1..15.
// Macro BLOCB_ARB_RR_EN: defined selects round-robin between simultaneous
// requests; undefined selects fixed priority with requester 0 winning.
// -----------------------------------------------------------------------------
module blocb_arbiter #(
   parameter int unsigned SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   blocb_arbiter_if.slave  bus
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               gnt0_q, gnt0_d;
   logic               gnt1_q, gnt1_d;
   logic [2:0]         blk_q, blk_d;
   logic               done_q, done_d;
   logic               res_q, res_d;
   logic               res_id_q, res_id_d;
   logic               owner_q, owner_d;
   logic               pick1_c;

   // Winner select: high means requester 1 is granted this arbitration.
`ifdef BLOCB_ARB_RR_EN
   logic               last_q, last_d;

   // On a tie, serve whichever requester was not served last.
   assign pick1_c = bus.req1 & (~bus.req0 | ~last_q);
`else
   assign pick1_c = bus.req1 & ~bus.req0;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      blk_d    = blk_q;
      done_d   = 1'b0;
      res_d    = res_q;
      res_id_d = res_id_q;
      owner_d  = owner_q;
`ifdef BLOCB_ARB_RR_EN
      last_d   = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               gnt0_d  = ~pick1_c;
               gnt1_d  = pick1_c;
               blk_d   = pick1_c ? bus.abc1 : bus.abc0;
               owner_d = pick1_c;
               cnt_d   = CNT_W'(SETTLE - 1);
               state_d = DRIVE;
`ifdef BLOCB_ARB_RR_EN
               last_d  = pick1_c;
`endif
            end
         end
         DRIVE: begin
            if (cnt_q == '0) begin
               res_d    = bus.blk_y;
               res_id_d = owner_q;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         blk_q    <= 3'b000;
         done_q   <= 1'b0;
         res_q    <= 1'b0;
         res_id_q <= 1'b0;
         owner_q  <= 1'b0;
`ifdef BLOCB_ARB_RR_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         blk_q    <= blk_d;
         done_q   <= done_d;
         res_q    <= res_d;
         res_id_q <= res_id_d;
         owner_q  <= owner_d;
`ifdef BLOCB_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bus.gnt0   = gnt0_q;
   assign bus.gnt1   = gnt1_q;
   assign bus.blk_a  = blk_q[2];
   assign bus.blk_b  = blk_q[1];
   assign bus.blk_c  = blk_q[0];
   assign bus.done   = done_q;
   assign bus.res    = res_q;
   assign bus.res_id = res_id_q;

endmodule

// File: tb/tb_blocb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_blocb_arbiter
// Two arbiter instances (SETTLE=2 with a y=(a&b)|c stub, SETTLE=1 with a
// bench-driven blk_y) checked every cycle against a transaction-timeline
// model, plus directed scenarios and a randomized phase with reset pulses.
// -----------------------------------------------------------------------------
module tb_blocb_arbiter;

   localparam int unsigned S0 = 2;
   localparam int unsigned S1 = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   blocb_arbiter_if ia ();
   blocb_arbiter_if ib ();

   logic       req0_t [2];
   logic       req1_t [2];
   logic [2:0] abc0_t [2];
   logic [2:0] abc1_t [2];
   logic       y1_t;

   assign ia.req0  = req0_t[0];
   assign ia.req1  = req1_t[0];
   assign ia.abc0  = abc0_t[0];
   assign ia.abc1  = abc1_t[0];
   assign ia.blk_y = (ia.blk_a & ia.blk_b) | ia.blk_c;
   assign ib.req0  = req0_t[1];
   assign ib.req1  = req1_t[1];
   assign ib.abc0  = abc0_t[1];
   assign ib.abc1  = abc1_t[1];
   assign ib.blk_y = y1_t;

   blocb_arbiter #(.SETTLE(S0)) u_s2 (.clk(clk), .rst_n(rst_n), .bus(ia));
   blocb_arbiter #(.SETTLE(S1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(ib));

   logic       o_gnt0 [2];
   logic       o_gnt1 [2];
   logic       o_done [2];
   logic       o_res  [2];
   logic       o_rid  [2];
   logic [2:0] o_blk  [2];

   assign o_gnt0[0] = ia.gnt0;
   assign o_gnt1[0] = ia.gnt1;
   assign o_done[0] = ia.done;
   assign o_res[0]  = ia.res;
   assign o_rid[0]  = ia.res_id;
   assign o_blk[0]  = {ia.blk_a, ia.blk_b, ia.blk_c};
   assign o_gnt0[1] = ib.gnt0;
   assign o_gnt1[1] = ib.gnt1;
   assign o_done[1] = ib.done;
   assign o_res[1]  = ib.res;
   assign o_rid[1]  = ib.res_id;
   assign o_blk[1]  = {ib.blk_a, ib.blk_b, ib.blk_c};

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;
   bit chk_en = 1'b0;
   bit mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int settle_of(input int k);
      return (k == 0) ? int'(S0) : int'(S1);
   endfunction

   function automatic logic stub_y(input logic [2:0] v);
      return (v[2] & v[1]) | v[0];
   endfunction

   // Model: each grant opens a window [g, g+S] of operands held, a capture of
   // y at the last DRIVE cycle g+S-1, done at g+S, and IDLE again at g+S+1.
   int         g_cyc   [2];
   int         free_at [2];
   logic       own     [2];
   logic [2:0] m_blk   [2];
   logic       m_res   [2];
   logic       m_rid   [2];
   logic       e_gnt0  [2];
   logic       e_gnt1  [2];
   logic       e_done  [2];
`ifdef BLOCB_ARB_RR_EN
   logic       m_last  [2];
`endif
   int         mc, mn, ms;
   logic       my, mw;

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            g_cyc[k]   = -1000;
            free_at[k] = 0;
            own[k]     = 1'b0;
            m_blk[k]   = 3'b000;
            m_res[k]   = 1'b0;
            m_rid[k]   = 1'b0;
            e_gnt0[k]  = 1'b0;
            e_gnt1[k]  = 1'b0;
            e_done[k]  = 1'b0;
`ifdef BLOCB_ARB_RR_EN
            m_last[k]  = 1'b1;
`endif
         end else begin
            mc = cyc;
            mn = mc + 1;
            ms = settle_of(k);
            my = (k == 0) ? stub_y(m_blk[k]) : y1_t;
            if (mc == g_cyc[k] + ms - 1) begin
               m_res[k] = my;
               m_rid[k] = own[k];
            end
            if (mc >= free_at[k] && (req0_t[k] || req1_t[k])) begin
`ifdef BLOCB_ARB_RR_EN
               mw = (req0_t[k] && req1_t[k]) ? ~m_last[k] : req1_t[k];
               m_last[k] = mw;
`else
               mw = ~req0_t[k];
`endif
               own[k]     = mw;
               m_blk[k]   = mw ? abc1_t[k] : abc0_t[k];
               g_cyc[k]   = mn;
               free_at[k] = mn + ms + 1;
            end
            e_gnt0[k] = (mn == g_cyc[k]) && !own[k];
            e_gnt1[k] = (mn == g_cyc[k]) && own[k];
            e_done[k] = (mn == g_cyc[k] + ms);
         end
      end
   end

   int   gq  [$];
   int   gcq [$];
   logic rq  [$];

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("s%0d.gnt0", settle_of(k)),   8'(o_gnt0[k]), 8'(e_gnt0[k]));
            check($sformatf("s%0d.gnt1", settle_of(k)),   8'(o_gnt1[k]), 8'(e_gnt1[k]));
            check($sformatf("s%0d.blk", settle_of(k)),    8'(o_blk[k]),  8'(m_blk[k]));
            check($sformatf("s%0d.done", settle_of(k)),   8'(o_done[k]), 8'(e_done[k]));
            check($sformatf("s%0d.res", settle_of(k)),    8'(o_res[k]),  8'(m_res[k]));
            check($sformatf("s%0d.res_id", settle_of(k)), 8'(o_rid[k]),  8'(m_rid[k]));
            check($sformatf("s%0d.gnt_excl", settle_of(k)), 8'(o_gnt0[k] & o_gnt1[k]), 8'd0);
         end
      end
      if (mon_en) begin
         if (o_gnt0[0] || o_gnt1[0]) begin
            gq.push_back(int'(o_gnt1[0]));
            gcq.push_back(cyc);
         end
         if (o_done[0]) rq.push_back(o_res[0]);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      for (int k = 0; k < 2; k++) begin
         req0_t[k] = 1'b0;
         req1_t[k] = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check({tag, ".gnt0"},   8'(o_gnt0[k]), 8'd0);
         check({tag, ".gnt1"},   8'(o_gnt1[k]), 8'd0);
         check({tag, ".done"},   8'(o_done[k]), 8'd0);
         check({tag, ".res"},    8'(o_res[k]),  8'd0);
         check({tag, ".res_id"}, 8'(o_rid[k]),  8'd0);
         check({tag, ".blk"},    8'(o_blk[k]),  8'd0);
      end
   endtask

   logic exp_id  [4];
   logic exp_res [4];
   logic yv;

   initial begin
      clear_reqs();
      for (int k = 0; k < 2; k++) begin
         abc0_t[k] = 3'b000;
         abc1_t[k] = 3'b000;
      end
      y1_t = 1'b0;
      step(3);
      check_all_zero("reset");
      chk_en = 1'b1;
      rst_n  = 1'b1;
      step(2);

      // Single request, SETTLE=2.
      req0_t[0] = 1'b1;
      abc0_t[0] = 3'b110;
      step(1);
      check("single.gnt0", 8'(o_gnt0[0]), 8'd1);
      check("single.blk1", 8'(o_blk[0]), 8'(3'b110));
      step(1);
      req0_t[0] = 1'b0;
      check("single.blk2", 8'(o_blk[0]), 8'(3'b110));
      step(1);
      check("single.done", 8'(o_done[0]), 8'd1);
      check("single.res",  8'(o_res[0]),  8'd1);
      check("single.rid",  8'(o_rid[0]),  8'd0);
      step(1);
      check("single.done_off", 8'(o_done[0]), 8'd0);
      step(2);

      // Output zero from requester 1.
      req1_t[0] = 1'b1;
      abc1_t[0] = 3'b100;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         if (i == 2) req1_t[0] = 1'b0;
         check("zero.gnt0", 8'(o_gnt0[0]), 8'd0);
         if (i == 3) begin
            check("zero.done", 8'(o_done[0]), 8'd1);
            check("zero.res",  8'(o_res[0]),  8'd0);
            check("zero.rid",  8'(o_rid[0]),  8'd1);
         end
      end
      step(3);

      // Simultaneous requests held high.
`ifdef BLOCB_ARB_RR_EN
      exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_res = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      exp_id  = '{1'b0, 1'b0, 1'b0, 1'b0};
      exp_res = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
      gq.delete();
      gcq.delete();
      rq.delete();
      mon_en    = 1'b1;
      abc0_t[0] = 3'b001;
      abc1_t[0] = 3'b000;
      req0_t[0] = 1'b1;
      req1_t[0] = 1'b1;
      step(4 * int'(S0 + 2));
      mon_en = 1'b0;
      check("both.n_gnt", 8'(gq.size()), 8'd4);
      check("both.n_res", 8'(rq.size()), 8'd4);
      for (int i = 0; i < 4 && i < gq.size(); i++)
         check($sformatf("both.gnt_id%0d", i), 8'(gq[i]), 8'(exp_id[i]));
      for (int i = 0; i < 4 && i < rq.size(); i++)
         check($sformatf("both.res%0d", i), 8'(rq[i]), 8'(exp_res[i]));
      for (int i = 1; i < gcq.size(); i++)
         check($sformatf("both.gap%0d", i), 8'(gcq[i] - gcq[i-1]), 8'(S0 + 2));
      req0_t[0] = 1'b0;
      step(1);
      check("both.gnt1_after", 8'(o_gnt1[0]), 8'd1);
      check("both.gnt0_after", 8'(o_gnt0[0]), 8'd0);
      req1_t[0] = 1'b0;
      step(6);

      // Reset during DRIVE, then a tie right after reset.
      req0_t[0] = 1'b1;
      abc0_t[0] = 3'b111;
      req0_t[1] = 1'b1;
      abc0_t[1] = 3'b011;
      step(1);
      clear_reqs();
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_mid");
      step(1);
      for (int k = 0; k < 2; k++) begin
         req0_t[k] = 1'b1;
         req1_t[k] = 1'b1;
         abc1_t[k] = 3'b101;
      end
      rst_n = 1'b1;
      step(1);
      for (int k = 0; k < 2; k++) begin
         check("rst_first.gnt0", 8'(o_gnt0[k]), 8'd1);
         check("rst_first.gnt1", 8'(o_gnt1[k]), 8'd0);
      end
      clear_reqs();
      step(6);

      // SETTLE=1: res takes blk_y of the single DRIVE cycle.
      for (int v = 0; v < 2; v++) begin
         yv        = v[0];
         y1_t      = ~yv;
         req0_t[1] = 1'b1;
         abc0_t[1] = 3'b010;
         step(1);
         y1_t      = yv;
         req0_t[1] = 1'b0;
         req1_t[1] = 1'b1;
         step(1);
         y1_t      = ~yv;
         check("s1dir.done",   8'(o_done[1]), 8'd1);
         check("s1dir.res",    8'(o_res[1]),  8'(yv));
         check("s1dir.rid",    8'(o_rid[1]),  8'd0);
         check("s1dir.no_gnt", 8'(o_gnt1[1]), 8'd0);
         req1_t[1] = 1'b0;
         step(3);
      end

      // Randomized traffic with occasional asynchronous reset pulses.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) begin
            req0_t[k] = ($urandom_range(0, 2) == 0);
            req1_t[k] = ($urandom_range(0, 2) == 0);
            abc0_t[k] = 3'($urandom_range(0, 7));
            abc1_t[k] = 3'($urandom_range(0, 7));
         end
         y1_t = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end else begin
            step(1);
         end
      end
      clear_reqs();
      step(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
